// File: rtl/fetch_sequencer.sv
// Fetch/execute control sequencer: drives PC update strobes, runs the
// instruction-memory handshake and selects the redirect after execute.
module fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned ACK_TIMEOUT  = 255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_PC,
   output logic        o_nextPC_DV,
   output logic        o_jump_DV,
   output logic [31:0] o_jump_address,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_data,
   output logic [31:0] o_instr,
   output logic        o_instr_DV,
   input  logic        i_exec_done,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   input  logic        i_trap,
   output logic        o_halted,
   output logic [1:0]  o_fault_cause
);

   localparam int unsigned CNT_W = (ACK_TIMEOUT == 0) ? 1 : $clog2(ACK_TIMEOUT + 1);

   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

   typedef enum logic [2:0] {
      S_BOOT,
      S_UPDATE,
      S_FETCH,
      S_EXEC,
      S_HALT
   } state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_d;
   logic               next_dv_d, jump_dv_d, req_d, instr_dv_d, halted_d;
   logic [31:0]        jump_addr_d, instr_d;
   logic [1:0]         cause_d;
   logic               next_pc_aligned;

   // Fetch address is the PC register itself.
   assign o_imem_addr = i_PC;

   // Low bits of the PC after this cycle's strobe; +4 preserves alignment.
   assign next_pc_aligned = o_jump_DV ? (o_jump_address[1:0] == 2'b00)
                                      : (i_PC[1:0] == 2'b00);

   // State and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state          <= S_BOOT;
         wait_cnt       <= '0;
         o_nextPC_DV    <= 1'b0;
         o_jump_DV      <= 1'b0;
         o_jump_address <= 32'h0;
         o_imem_req     <= 1'b0;
         o_instr        <= 32'h0;
         o_instr_DV     <= 1'b0;
         o_halted       <= 1'b0;
         o_fault_cause  <= 2'b00;
      end else begin
         state          <= state_d;
         wait_cnt       <= wait_cnt_d;
         o_nextPC_DV    <= next_dv_d;
         o_jump_DV      <= jump_dv_d;
         o_jump_address <= jump_addr_d;
         o_imem_req     <= req_d;
         o_instr        <= instr_d;
         o_instr_DV     <= instr_dv_d;
         o_halted       <= halted_d;
         o_fault_cause  <= cause_d;
      end
   end

   // Next state and next values of the registered outputs.
   always_comb begin
      state_d     = state;
      wait_cnt_d  = wait_cnt;
      next_dv_d   = 1'b0;
      jump_dv_d   = 1'b0;
      jump_addr_d = o_jump_address;
      req_d       = 1'b0;
      instr_d     = o_instr;
      instr_dv_d  = 1'b0;
      halted_d    = 1'b0;
      cause_d     = o_fault_cause;

      case (state)
         S_BOOT: begin
            jump_dv_d   = 1'b1;
            jump_addr_d = RESET_VECTOR;
            state_d     = S_UPDATE;
         end

         S_UPDATE: begin
            // Request only if the PC being loaded now is word aligned.
            wait_cnt_d = '0;
            req_d      = next_pc_aligned;
            state_d    = S_FETCH;
         end

         S_FETCH: begin
            if (i_PC[1:0] != 2'b00) begin
               halted_d = 1'b1;
               cause_d  = CAUSE_MISALIGN;
               state_d  = S_HALT;
            end else if (i_imem_ack) begin
               instr_d    = i_imem_data;
               instr_dv_d = 1'b1;
               wait_cnt_d = '0;
               state_d    = S_EXEC;
            end else if ((ACK_TIMEOUT != 0) && ((32'(wait_cnt) + 32'd1) == ACK_TIMEOUT)) begin
               halted_d = 1'b1;
               cause_d  = CAUSE_TIMEOUT;
               state_d  = S_HALT;
            end else begin
               wait_cnt_d = wait_cnt + CNT_W'(1);
               req_d      = 1'b1;
            end
         end

         S_EXEC: begin
            // Redirect priority: trap, then branch, then sequential.
            if (i_exec_done) begin
               if (i_trap) begin
                  jump_dv_d   = 1'b1;
                  jump_addr_d = TRAP_VECTOR;
               end else if (i_branch_taken) begin
                  jump_dv_d   = 1'b1;
                  jump_addr_d = i_branch_target;
               end else begin
                  next_dv_d = 1'b1;
               end
               state_d = S_UPDATE;
            end
         end

         S_HALT: begin
            halted_d = 1'b1;
         end

         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: reactive imem/execute responders, a program
// counter, a behavioural reference model and directed scenario checks.
module tb_fetch_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;
   localparam int W_BOOT = 0, W_UPDATE = 1, W_FETCH = 2, W_EXEC = 3, W_HALT = 4;
   localparam int K_NONE = 0, K_SEQ = 1, K_JUMP = 2;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [31:0] pc = 32'hDEAD_BEE0;
   logic        o_nextPC_DV, o_jump_DV, o_imem_req, o_instr_DV, o_halted;
   logic [31:0] o_jump_address, o_imem_addr, o_instr;
   logic [1:0]  o_fault_cause;
   logic        i_imem_ack = 1'b0, i_exec_done = 1'b0, i_branch_taken = 1'b0, i_trap = 1'b0;
   logic [31:0] i_imem_data = 32'h0, i_branch_target = 32'h0;

   // Second instance with a short timeout and a memory that never answers.
   logic [31:0] pc_to = 32'h0;
   logic        to_next, to_jump, to_req, to_idv, to_halted;
   logic [31:0] to_jaddr, to_addr, to_instr;
   logic [1:0]  to_cause;

   fetch_sequencer dut (
      .i_clk(clk), .i_reset(i_reset), .i_PC(pc),
      .o_nextPC_DV(o_nextPC_DV), .o_jump_DV(o_jump_DV), .o_jump_address(o_jump_address),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
      .o_instr(o_instr), .o_instr_DV(o_instr_DV),
      .i_exec_done(i_exec_done), .i_branch_taken(i_branch_taken),
      .i_branch_target(i_branch_target), .i_trap(i_trap),
      .o_halted(o_halted), .o_fault_cause(o_fault_cause)
   );

   fetch_sequencer #(.ACK_TIMEOUT(4)) dut_to (
      .i_clk(clk), .i_reset(i_reset), .i_PC(pc_to),
      .o_nextPC_DV(to_next), .o_jump_DV(to_jump), .o_jump_address(to_jaddr),
      .o_imem_req(to_req), .o_imem_addr(to_addr),
      .i_imem_ack(1'b0), .i_imem_data(32'h0),
      .o_instr(to_instr), .o_instr_DV(to_idv),
      .i_exec_done(1'b0), .i_branch_taken(1'b0),
      .i_branch_target(32'h0), .i_trap(1'b0),
      .o_halted(to_halted), .o_fault_cause(to_cause)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // Program counter registers driven by the strobes.
   always @(posedge clk) begin
      if (o_jump_DV)        pc <= o_jump_address;
      else if (o_nextPC_DV) pc <= pc + 32'd4;
      if (to_jump)          pc_to <= to_jaddr;
      else if (to_next)     pc_to <= pc_to + 32'd4;
   end

   // Cycles since reset release: 0 during reset and in the first cycle after.
   int since_rel = 0;
   always @(posedge clk) since_rel <= i_reset ? 0 : since_rel + 1;

   // Reference model: what the sequencer is doing and what it must show.
   logic        m_valid = 1'b0, m_first = 1'b0;
   logic [31:0] m_pc = 32'hDEAD_BEE0, m_instr = 32'h0, m_jaddr = 32'h0;
   logic [1:0]  m_cause = 2'b00;
   int          m_where = W_BOOT, m_kind = K_NONE, m_wait = 0;

   always @(posedge clk) begin
      if (i_reset) begin
         m_valid = 1'b1; m_where = W_BOOT; m_kind = K_NONE; m_first = 1'b0;
         m_instr = 32'h0; m_jaddr = 32'h0; m_cause = 2'b00; m_wait = 0;
      end else begin
         case (m_where)
            W_BOOT: begin m_kind = K_JUMP; m_jaddr = RV; m_where = W_UPDATE; end
            W_UPDATE: begin
               if (m_kind == K_JUMP)     m_pc = m_jaddr;
               else if (m_kind == K_SEQ) m_pc = m_pc + 32'd4;
               m_kind = K_NONE; m_wait = 0; m_where = W_FETCH;
            end
            W_FETCH: begin
               if (m_pc[1:0] != 2'b00) begin m_cause = 2'b01; m_where = W_HALT; end
               else if (i_imem_ack) begin m_instr = imem_word(m_pc); m_first = 1'b1; m_where = W_EXEC; end
               else begin
                  m_wait = m_wait + 1;
                  if (m_wait == 255) begin m_cause = 2'b10; m_where = W_HALT; end
               end
            end
            W_EXEC: begin
               m_first = 1'b0;
               if (i_exec_done) begin
                  if (i_trap)              begin m_kind = K_JUMP; m_jaddr = TV; end
                  else if (i_branch_taken) begin m_kind = K_JUMP; m_jaddr = i_branch_target; end
                  else                     m_kind = K_SEQ;
                  m_where = W_UPDATE;
               end
            end
            default: ;
         endcase
      end
   end

   int n_tests = 0, n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Responder knobs and monitor state.
   logic        ack_en = 1'b1, ack_force = 1'b0, br_knob = 1'b0, trap_knob = 1'b0;
   logic [31:0] tgt_knob = 32'h0, req_addr = 32'h0, last_jaddr = 32'h0;
   int ack_delay = 0, done_delay = 2, ack_k = 0, ex_k = 0;
   logic ex_act = 1'b0, first_req_seen = 1'b0;
   int first_req_cyc = 0, n_jump = 0, n_next = 0, n_idv = 0, bad_req = 0;
   int strobe_in_req = 0, addr_chg = 0, req_run = 0, to_req_cycles = 0, to_halt_cyc = 0;
   logic [31:0] fetch_log[$];

   task automatic wait_fetches(input int n, input string nm);
      int k = 0;
      while (fetch_log.size() < n && k < 200) begin @(negedge clk); #1; k++; end
      check(nm, 32'(fetch_log.size()), 32'(n));
   endtask

   initial begin
      fork
         // Per-cycle compare against the model, monitors, then responders.
         forever begin
            @(negedge clk);
            if (m_valid) begin
               check("req", 32'(o_imem_req), 32'(m_where == W_FETCH && m_pc[1:0] == 2'b00));
               if (m_where == W_FETCH && m_pc[1:0] == 2'b00) check("imem_addr", o_imem_addr, m_pc);
               check("jump_dv", 32'(o_jump_DV), 32'(m_where == W_UPDATE && m_kind == K_JUMP));
               check("next_dv", 32'(o_nextPC_DV), 32'(m_where == W_UPDATE && m_kind == K_SEQ));
               check("jump_addr", o_jump_address, m_jaddr);
               check("instr", o_instr, m_instr);
               check("instr_dv", 32'(o_instr_DV), 32'(m_where == W_EXEC && m_first));
               check("halted", 32'(o_halted), 32'(m_where == W_HALT));
               check("cause", 32'(o_fault_cause), 32'(m_cause));
            end
            if (since_rel == 0) begin
               first_req_seen = 1'b0; to_req_cycles = 0; to_halt_cyc = 0; ex_act = 1'b0;
            end
            if (o_imem_req && !first_req_seen) begin first_req_seen = 1'b1; first_req_cyc = since_rel + 1; end
            if (o_jump_DV) begin n_jump++; last_jaddr = o_jump_address; end
            if (o_nextPC_DV) n_next++;
            if (o_instr_DV) n_idv++;
            if (o_imem_req && o_imem_addr[1:0] != 2'b00) bad_req++;
            if (o_imem_req && (o_jump_DV || o_nextPC_DV)) strobe_in_req++;
            if (o_imem_req) begin
               if (req_run > 0 && o_imem_addr != req_addr) addr_chg++;
               req_addr = o_imem_addr; req_run++;
            end else req_run = 0;
            if (to_req) to_req_cycles++;
            if (to_halted && to_halt_cyc == 0) to_halt_cyc = since_rel + 1;
            // Instruction memory.
            i_imem_ack = ack_force;
            if (o_imem_req && ack_en) begin
               if (ack_k == ack_delay) begin i_imem_ack = 1'b1; fetch_log.push_back(o_imem_addr); end
               ack_k++;
            end else if (!o_imem_req) ack_k = 0;
            i_imem_data = imem_word(o_imem_addr);
            // Execute stage.
            i_exec_done = 1'b0; i_branch_taken = 1'b0; i_trap = 1'b0;
            if (o_instr_DV) begin ex_act = 1'b1; ex_k = 0; end
            if (ex_act) begin
               if (ex_k == done_delay) begin
                  i_exec_done = 1'b1; i_branch_taken = br_knob; i_trap = trap_knob;
                  i_branch_target = tgt_knob; ex_act = 1'b0;
               end else ex_k++;
            end
         end
      join_none

      // Boot and sequential execution.
      repeat (2) @(negedge clk);
      #1 i_reset = 1'b0;
      wait_fetches(3, "seq_fetch_count");
      check("first_req_cycle", 32'(first_req_cyc), 32'd3);
      check("seq_addr0", fetch_log[0], 32'h0);
      check("seq_addr1", fetch_log[1], 32'h4);
      check("seq_addr2", fetch_log[2], 32'h8);
      check("seq_jump_count", 32'(n_jump), 32'd1);
      check("seq_next_count", 32'(n_next), 32'd2);
      @(negedge clk); #1;
      check("instr_at_8", o_instr, 32'h1357_9BD7);
      check("instr_dv_at_8", 32'(o_instr_DV), 32'd1);

      // Short-timeout instance halted long ago.
      check("to_req_cycles", 32'(to_req_cycles), 32'd4);
      check("to_halt_cycle", 32'(to_halt_cyc), 32'd7);
      check("to_cause", 32'(to_cause), 32'd2);
      check("to_req_low", 32'(to_req), 32'd0);

      // Taken branch, then trap beating branch.
      br_knob = 1'b1; tgt_knob = 32'h40;
      wait_fetches(4, "br_fetch_count");
      check("br_addr", fetch_log[3], 32'h40);
      trap_knob = 1'b1; tgt_knob = 32'h80;
      wait_fetches(5, "trap_fetch_count");
      check("trap_addr", fetch_log[4], 32'h100);

      // Misaligned branch target.
      trap_knob = 1'b0; tgt_knob = 32'h42;
      for (int k = 0; k < 50 && !o_halted; k++) begin @(negedge clk); #1; end
      check("mis_halted", 32'(o_halted), 32'd1);
      check("mis_cause", 32'(o_fault_cause), 32'd1);
      check("mis_no_req", 32'(bad_req), 32'd0);
      repeat (5) @(negedge clk); #1;
      check("mis_fetch_count", 32'(fetch_log.size()), 32'd5);
      check("mis_jump_count", 32'(n_jump), 32'd4);
      check("mis_next_count", 32'(n_next), 32'd2);
      check("mis_still_halted", 32'(o_halted), 32'd1);
      br_knob = 1'b0;

      // Reset out of HALT; registers must clear.
      ack_en = 1'b0;
      @(negedge clk); #1 i_reset = 1'b1;
      @(negedge clk); #1;
      check("rst_outputs", {27'h0, o_imem_req, o_jump_DV, o_nextPC_DV, o_instr_DV, o_halted}, 32'h0);
      check("rst_cause", 32'(o_fault_cause), 32'd0);
      check("rst_instr", o_instr, 32'h0);
      check("rst_jaddr", o_jump_address, 32'h0);
      @(negedge clk); #1 i_reset = 1'b0;

      // Reset while a request is pending, with an ack in the reset cycle.
      for (int k = 0; k < 20 && !o_imem_req; k++) begin @(negedge clk); #1; end
      check("mf_req_pending", 32'(o_imem_req), 32'd1);
      @(negedge clk); #1 ack_force = 1'b1;
      @(negedge clk); #1 i_reset = 1'b1; ack_force = 1'b0;
      @(negedge clk); #1;
      check("mf_req_dropped", 32'(o_imem_req), 32'd0);
      check("mf_instr_zero", o_instr, 32'h0);
      @(negedge clk); #1 i_reset = 1'b0;

      // Reboot with a 10-cycle ack stall.
      begin
         int j0, f0, i0;
         j0 = n_jump; f0 = fetch_log.size(); i0 = n_idv;
         ack_en = 1'b1; ack_delay = 10; done_delay = 0;
         wait_fetches(f0 + 1, "stall_fetch_count");
         check("reboot_jump_count", 32'(n_jump - j0), 32'd1);
         check("reboot_jaddr", last_jaddr, 32'h0);
         check("reboot_addr", fetch_log[f0], 32'h0);
         check("stall_req_cycles", 32'(req_run), 32'd11);
         check("stall_addr_stable", 32'(addr_chg), 32'd0);
         check("stall_no_strobe", 32'(strobe_in_req), 32'd0);
         @(negedge clk); #1;
         check("stall_one_idv", 32'(n_idv - i0), 32'd1);
         check("stall_instr", o_instr, 32'h1357_9BDF);
      end
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM that drives the program counter's update strobes (next-PC / jump) and runs the instruction-memory fetch handshake.
- Issues the boot jump to the reset vector, fetches the instruction at the current PC, and hands it to execute.
- After execute completes, selects sequential, branch or trap redirect.
- Sits between the program counter, instruction memory port and the execute stage.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded after reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on i_trap.
- ACK_TIMEOUT, 255, maximum FETCH cycles without ack before fault; 0 disables the timeout.

Ports:
- i_clk  in  1  clock, all logic on posedge.
- i_reset  in  1  synchronous active-high reset.
- i_PC  in  32  current PC from the program counter.
- o_nextPC_DV  out  1  one-cycle strobe: PC <= PC+4.
- o_jump_DV  out  1  one-cycle strobe: PC <= o_jump_address.
- o_jump_address  out  32  jump target, valid while o_jump_DV=1.
- o_imem_req  out  1  fetch request, level, held until ack.
- o_imem_addr  out  32  fetch address.
- i_imem_ack  in  1  fetch complete, data valid this cycle.
- i_imem_data  in  32  fetched instruction.
- o_instr  out  32  latched instruction.
- o_instr_DV  out  1  one-cycle strobe, o_instr newly valid.
- i_exec_done  in  1  execute finished current instruction.
- i_branch_taken  in  1  redirect to i_branch_target (sampled with i_exec_done).
- i_branch_target  in  32  branch target.
- i_trap  in  1  redirect to TRAP_VECTOR (sampled with i_exec_done).
- o_halted  out  1  FSM in HALT.
- o_fault_cause  out  2  00 none, 01 misaligned PC, 10 fetch timeout.

Behaviour:
- Reset (any cycle, any state): state=BOOT, timeout counter=0.
- Reset values: all strobes, o_imem_req, o_halted = 0; o_instr, o_jump_address, o_fault_cause = 0.
- Reset mid-fetch drops o_imem_req the following cycle. An ack arriving during or after reset is ignored.
- All outputs are registered, except o_imem_addr, which is a direct copy of i_PC (itself a register).
- States and transitions:
  - BOOT: register o_jump_DV=1, o_jump_address=RESET_VECTOR; go to UPDATE.
  - UPDATE: the strobe is high for exactly this one cycle; the PC changes at the end of it. Go to FETCH.
  - FETCH, on entry: if i_PC[1:0]!=0, go to HALT with cause 01, and no request is issued.
  - FETCH, otherwise: o_imem_req=1, o_imem_addr=i_PC.
  - FETCH, i_imem_ack=1: latch i_imem_data into o_instr, pulse o_instr_DV (high in the first EXEC cycle), clear counter, go to EXEC.
  - FETCH, no ack: counter++. When counter==ACK_TIMEOUT (ACK_TIMEOUT!=0), go to HALT with cause 10 and deassert req.
  - EXEC: wait for i_exec_done; it may already be 1 in the first EXEC cycle. On done, select redirect with priority trap > branch > sequential:
    - trap: o_jump_DV, target TRAP_VECTOR.
    - branch: o_jump_DV, target i_branch_target.
    - sequential: o_nextPC_DV.
    - Go to UPDATE.
  - HALT: o_halted=1, no strobes or requests; exit only by reset.
- Invariant: o_nextPC_DV and o_jump_DV are never high together; at most one strobe per instruction.
- i_imem_ack outside FETCH and i_exec_done outside EXEC are ignored. Branch/trap inputs are ignored unless i_exec_done=1.
- Minimum loop: UPDATE -> FETCH (ack same cycle) -> EXEC (done same cycle) -> UPDATE = 3 cycles per instruction.
- Boot: the first request is seen in cycle 3 after reset release (BOOT, UPDATE, FETCH).
- Sequential wrap: PC 32'hFFFF_FFFC + 4 wraps to 0 in the counter. The sequencer treats this as normal and fetches from 0.
- Branch target misalignment is detected at the following FETCH entry (cause 01), not at EXEC.

Test Plan:
- Boot: reset 2 cycles, imem acks immediately -> one o_jump_DV pulse with address 0. First o_imem_req has addr 0 in cycle 3 after release. o_instr_DV follows.
- Sequential: 3 instructions, exec_done 2 cycles after o_instr_DV -> o_nextPC_DV pulses; fetch addrs 0, 4, 8; o_jump_DV never high.
- Redirect priority:
  - done with branch_taken=1, target 32'h40 -> next fetch at 32'h40.
  - done with trap=1 and branch_taken=1 together -> jump to 32'h100.
- Faults:
  - Branch target 32'h42 -> HALT, o_fault_cause=01, no request issued.
  - ACK_TIMEOUT=4, ack withheld -> HALT after 4 FETCH cycles, cause 10, req low.
- Reset mid-fetch: assert i_reset with req pending and ack arriving the same cycle -> ack ignored, o_instr unchanged (0). BOOT jump re-issued to RESET_VECTOR.
- Stall: ack delayed 10 cycles (timeout 255) -> req and addr held stable throughout; single o_instr_DV pulse; no strobe during the wait.
